alarm_ctrl_multi: RTL and testbench
===================================

Name: alarm_ctrl_multi

Overview:
Multi-channel alarm controller with snooze and display selection for the alarm-clock datapath. Watches NUM_ALARMS independently enabled alarm times against the current minute-of-day. Handles snooze with modulo-day wrap, a per-channel snooze limit and ring auto-timeout. Drives a registered display mux and an aggregate sound_alarm output.

Parameters:
NUM_ALARMS, 4, number of alarm channels (>=1)
TIME_W, 11, width of a minute-of-day value
MINUTES_PER_DAY, 1440, modulus for time arithmetic; must be <= 2**TIME_W
SNOOZE_MIN, 5, minutes added per snooze; must be < MINUTES_PER_DAY
MAX_SNOOZE, 3, snoozes allowed per ring episode; the next snooze acts as stop for that channel
RING_LIMIT, 10, ticks a channel may ring before auto-stop; 0 = never auto-stop

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
one_minute  in  1  single-cycle strobe, one per minute
snooze  in  1  single-cycle snooze request
stop_alarm  in  1  single-cycle stop request
alarm_en  in  NUM_ALARMS  per-channel enable
alarm_time  in  NUM_ALARMS*TIME_W  packed alarm times; channel i at [i*TIME_W +: TIME_W]
current_time  in  TIME_W  current minute-of-day
show_alarm  in  1  1 = display the selected alarm, 0 = display current_time
show_sel  in  SEL_W  channel to display; SEL_W = max(1, clog2(NUM_ALARMS))
display  out  TIME_W  registered display value
sound_alarm  out  1  OR of all ringing bits
ringing  out  NUM_ALARMS  per-channel RINGING state
snoozed  out  NUM_ALARMS  per-channel SNOOZED state

Behaviour:
- Reset (rst_n low, async): every channel IDLE; snooze_time, snooze_cnt and ring_cnt = 0; display = 0; ringing = 0; snoozed = 0; sound_alarm = 0.
- All outputs are registered. Every response is visible on the first clk edge after the strobe cycle (1-cycle latency).
- Per-channel FSM. States: IDLE, RINGING, SNOOZED. Priority within one cycle: disable > stop_alarm > snooze > one_minute.
- Disable: alarm_en[i] = 0 forces IDLE from any state and clears the channel's counters.
- stop_alarm: every channel goes to IDLE; snooze_cnt and ring_cnt cleared.
- IDLE: on one_minute with alarm_en[i] = 1 and current_time == alarm_time[i] -> RINGING; ring_cnt = 0; snooze_cnt = 0.
- RINGING + snooze:
  - snooze_cnt < MAX_SNOOZE -> SNOOZED; snooze_time = (current_time + SNOOZE_MIN) mod MINUTES_PER_DAY, implemented as one compare-and-subtract; snooze_cnt += 1.
  - snooze_cnt == MAX_SNOOZE -> IDLE, counters cleared.
- RINGING + one_minute: ring_cnt += 1. When RING_LIMIT != 0 and the incremented value == RING_LIMIT -> IDLE, counters cleared.
- SNOOZED + one_minute with current_time == snooze_time -> RINGING; ring_cnt = 0; snooze_cnt kept.
- SNOOZED ignores snooze and alarm_time matches.
- snooze acts only on RINGING channels. Channels not ringing in the same cycle still process one_minute normally.
- current_time >= MINUTES_PER_DAY never matches anything and never produces a snooze target.
- Display register, next value:
  - show_alarm = 0 -> current_time.
  - show_alarm = 1 and show_sel >= NUM_ALARMS -> current_time.
  - show_alarm = 1 and channel show_sel SNOOZED -> its snooze_time.
  - otherwise -> alarm_time[show_sel].
- Counter widths are sized for MAX_SNOOZE and RING_LIMIT and must not overflow.
- Reset asserted mid-ring or mid-snooze: all state cleared immediately. No ringing after release until a fresh tick match.

Test Plan:
1. alarm_en = 0001, ch0 = 420; tick with current_time = 420 -> next cycle ringing = 0001, sound_alarm = 1; display = 420 when show_alarm = 1, show_sel = 0.
2. Ch0 ringing at current_time = 1437; snooze -> snoozed = 0001, displayed snooze_time = 2 (wrap); tick at 2 -> ringing again; tick at 1 -> no change.
3. MAX_SNOOZE = 3: ring, snooze x3 with re-rings between; fourth snooze while ringing -> channel IDLE, sound_alarm = 0.
4. RING_LIMIT = 10: ring, then 10 ticks with no button -> IDLE after the 10th tick. Repeat with RING_LIMIT = 0 -> still ringing after 50 ticks.
5. Ch0 and ch2 both = 600, ch2 disabled; tick at 600 with stop_alarm in the same cycle -> ringing = 0. Repeat without stop -> ringing = 0001 only.
6. rst_n pulsed low mid-SNOOZED (asynchronous to clk) -> outputs 0 immediately; tick at the old snooze_time -> no ring.

Source files
------------

// File: rtl/alarm_ctrl_multi.sv
// Multi-channel alarm controller: per-channel IDLE/RINGING/SNOOZED FSMs with modulo-day snooze,
// a per-episode snooze limit, ring auto-timeout and a registered display mux.
module alarm_ctrl_multi #(
  parameter int unsigned NUM_ALARMS      = 4,
  parameter int unsigned TIME_W          = 11,
  parameter int unsigned MINUTES_PER_DAY = 1440,
  parameter int unsigned SNOOZE_MIN      = 5,
  parameter int unsigned MAX_SNOOZE      = 3,
  parameter int unsigned RING_LIMIT      = 10,
  parameter int unsigned SEL_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         one_minute,
  input  logic                         snooze,
  input  logic                         stop_alarm,
  input  logic [NUM_ALARMS-1:0]        alarm_en,
  input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
  input  logic [TIME_W-1:0]            current_time,
  input  logic                         show_alarm,
  input  logic [SEL_W-1:0]             show_sel,
  output logic [TIME_W-1:0]            display,
  output logic                         sound_alarm,
  output logic [NUM_ALARMS-1:0]        ringing,
  output logic [NUM_ALARMS-1:0]        snoozed
);

  localparam int unsigned SNZ_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int unsigned RING_W = (RING_LIMIT > 0) ? $clog2(RING_LIMIT + 1) : 1;

  localparam logic [TIME_W:0]  Mpd     = (TIME_W + 1)'(MINUTES_PER_DAY);
  localparam logic [TIME_W:0]  SnzMin  = (TIME_W + 1)'(SNOOZE_MIN);
  localparam logic [SNZ_W-1:0]  MaxSnz  = SNZ_W'(MAX_SNOOZE);
  localparam logic [RING_W-1:0] RingLim = RING_W'(RING_LIMIT);

  typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} state_e;

  state_e              state_q    [NUM_ALARMS];
  state_e              state_d    [NUM_ALARMS];
  logic [TIME_W-1:0]   snz_time_q [NUM_ALARMS];
  logic [TIME_W-1:0]   snz_time_d [NUM_ALARMS];
  logic [SNZ_W-1:0]    snz_cnt_q  [NUM_ALARMS];
  logic [SNZ_W-1:0]    snz_cnt_d  [NUM_ALARMS];
  logic [RING_W-1:0]   ring_cnt_q [NUM_ALARMS];
  logic [RING_W-1:0]   ring_cnt_d [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] ring_q, ring_d, snzd_q, snzd_d;
  logic [TIME_W-1:0]     disp_q, disp_d;
  logic                  sound_q;

  logic              time_ok;
  logic [TIME_W:0]   snz_sum;
  logic [TIME_W-1:0] snz_target;

  // Out-of-range times never match and never yield a snooze target.
  assign time_ok    = {1'b0, current_time} < Mpd;
  assign snz_sum    = {1'b0, current_time} + SnzMin;
  assign snz_target = TIME_W'((snz_sum >= Mpd) ? (snz_sum - Mpd) : snz_sum);

  always_comb begin
    logic [RING_W-1:0] ring_inc;
    ring_inc = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      state_d[i]    = state_q[i];
      snz_time_d[i] = snz_time_q[i];
      snz_cnt_d[i]  = snz_cnt_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];
      ring_inc      = ring_cnt_q[i] + RING_W'(1);

      if (!alarm_en[i] || stop_alarm) begin
        state_d[i]    = StIdle;
        snz_cnt_d[i]  = '0;
        ring_cnt_d[i] = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (one_minute && time_ok && current_time == alarm_time[i*TIME_W +: TIME_W]) begin
              state_d[i]    = StRinging;
              snz_cnt_d[i]  = '0;
              ring_cnt_d[i] = '0;
            end
          end
          StRinging: begin
            if (snooze) begin
              if (snz_cnt_q[i] >= MaxSnz) begin
                state_d[i]    = StIdle;
                snz_cnt_d[i]  = '0;
                ring_cnt_d[i] = '0;
              end else if (time_ok) begin
                state_d[i]    = StSnoozed;
                snz_time_d[i] = snz_target;
                snz_cnt_d[i]  = snz_cnt_q[i] + SNZ_W'(1);
              end
            end else if (one_minute && RING_LIMIT != 0) begin
              ring_cnt_d[i] = ring_inc;
              if (ring_inc == RingLim) begin
                state_d[i]    = StIdle;
                snz_cnt_d[i]  = '0;
                ring_cnt_d[i] = '0;
              end
            end
          end
          StSnoozed: begin
            if (one_minute && time_ok && current_time == snz_time_q[i]) begin
              state_d[i]    = StRinging;
              ring_cnt_d[i] = '0;
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end

      ring_d[i] = (state_d[i] == StRinging);
      snzd_d[i] = (state_d[i] == StSnoozed);
    end
  end

  // Unmatched selects (show_sel >= NUM_ALARMS) fall through to current_time.
  always_comb begin
    disp_d = current_time;
    if (show_alarm) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (show_sel == SEL_W'(i)) begin
          disp_d = (state_q[i] == StSnoozed) ? snz_time_q[i] : alarm_time[i*TIME_W +: TIME_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= StIdle;
        snz_time_q[i] <= '0;
        snz_cnt_q[i]  <= '0;
        ring_cnt_q[i] <= '0;
      end
      ring_q  <= '0;
      snzd_q  <= '0;
      disp_q  <= '0;
      sound_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= state_d[i];
        snz_time_q[i] <= snz_time_d[i];
        snz_cnt_q[i]  <= snz_cnt_d[i];
        ring_cnt_q[i] <= ring_cnt_d[i];
      end
      ring_q  <= ring_d;
      snzd_q  <= snzd_d;
      disp_q  <= disp_d;
      sound_q <= |ring_d;
    end
  end

  assign ringing     = ring_q;
  assign snoozed     = snzd_q;
  assign display     = disp_q;
  assign sound_alarm = sound_q;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Self-checking bench for alarm_ctrl_multi: vector table plus hand sequences for timeout,
// unlimited ringing and asynchronous reset; expectations flow through a scoreboard queue.
module tb_alarm_ctrl_multi;

  typedef struct {
    logic        tick;
    logic        snz;
    logic        stp;
    logic [3:0]  en;
    logic [10:0] a0;
    logic [10:0] cur;
    logic        show;
    logic [1:0]  sel;
    logic [3:0]  ring;
    logic [3:0]  snzd;
    logic [10:0] disp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        one_minute = 1'b0, snooze = 1'b0, stop_alarm = 1'b0, show_alarm = 1'b0;
  logic [3:0]  alarm_en = '0;
  logic [43:0] alarm_time = '0;
  logic [10:0] current_time = '0;
  logic [1:0]  show_sel = '0;

  logic [10:0] display, display_nl;
  logic        sound_alarm, sound_nl;
  logic [3:0]  ringing, snoozed, ringing_nl, snoozed_nl;

  int n_cmp = 0;
  int n_err = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  alarm_ctrl_multi dut (
    .clk(clk), .rst_n(rst_n), .one_minute(one_minute), .snooze(snooze),
    .stop_alarm(stop_alarm), .alarm_en(alarm_en), .alarm_time(alarm_time),
    .current_time(current_time), .show_alarm(show_alarm), .show_sel(show_sel),
    .display(display), .sound_alarm(sound_alarm), .ringing(ringing), .snoozed(snoozed)
  );

  alarm_ctrl_multi #(.RING_LIMIT(0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .one_minute(one_minute), .snooze(snooze),
    .stop_alarm(stop_alarm), .alarm_en(alarm_en), .alarm_time(alarm_time),
    .current_time(current_time), .show_alarm(show_alarm), .show_sel(show_sel),
    .display(display_nl), .sound_alarm(sound_nl), .ringing(ringing_nl), .snoozed(snoozed_nl)
  );

  function automatic vec_t mk(logic tick, logic snz, logic stp, logic [3:0] en, int a0, int cur,
                              logic show, int sel, logic [3:0] ring, logic [3:0] snzd, int disp);
    vec_t v;
    v.tick = tick; v.snz = snz; v.stp = stp; v.en = en;
    v.a0 = 11'(a0); v.cur = 11'(cur); v.show = show; v.sel = 2'(sel);
    v.ring = ring; v.snzd = snzd; v.disp = 11'(disp);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the next edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    one_minute   = v.tick;
    snooze       = v.snz;
    stop_alarm   = v.stp;
    alarm_en     = v.en;
    alarm_time   = {11'd0, 11'd600, 11'd1500, v.a0};
    current_time = v.cur;
    show_alarm   = v.show;
    show_sel     = v.sel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".ringing"}, int'(ringing), int'(e.ring));
    check({tag, ".snoozed"}, int'(snoozed), int'(e.snzd));
    check({tag, ".display"}, int'(display), int'(e.disp));
    check({tag, ".sound"},   int'(sound_alarm), int'(|e.ring));
  endtask

  initial begin
    // Basic ring, snooze wrap, snooze limit, invalid time, disable and stop priority.
    tbl.push_back(mk(1, 0, 0, 4'b0001,  420,  420, 1, 0, 4'b0001, 4'b0000,  420));
    tbl.push_back(mk(0, 0, 1, 4'b0001,  420,  421, 0, 0, 4'b0000, 4'b0000,  421));
    tbl.push_back(mk(1, 0, 0, 4'b0001, 1437, 1437, 1, 0, 4'b0001, 4'b0000, 1437));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 1437, 1437, 1, 0, 4'b0000, 4'b0001, 1437));
    tbl.push_back(mk(0, 0, 0, 4'b0001, 1437, 1437, 1, 0, 4'b0000, 4'b0001,    2));
    tbl.push_back(mk(1, 0, 0, 4'b0001, 1437,    1, 1, 0, 4'b0000, 4'b0001,    2));
    tbl.push_back(mk(1, 0, 0, 4'b0001, 1437,    2, 1, 0, 4'b0001, 4'b0000,    2));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 1437,  100, 1, 0, 4'b0000, 4'b0001, 1437));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 1437,  101, 1, 0, 4'b0000, 4'b0001,  105));
    tbl.push_back(mk(1, 0, 0, 4'b0001, 1437,  105, 1, 0, 4'b0001, 4'b0000,  105));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 1437,  200, 1, 0, 4'b0000, 4'b0001, 1437));
    tbl.push_back(mk(1, 0, 0, 4'b0001, 1437,  205, 1, 0, 4'b0001, 4'b0000,  205));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 1437,  300, 1, 0, 4'b0000, 4'b0000, 1437));
    tbl.push_back(mk(1, 0, 0, 4'b0010, 1437, 1500, 0, 0, 4'b0000, 4'b0000, 1500));
    tbl.push_back(mk(1, 0, 1, 4'b0001,  600,  600, 1, 2, 4'b0000, 4'b0000,  600));
    tbl.push_back(mk(1, 0, 0, 4'b0001,  600,  600, 0, 0, 4'b0001, 4'b0000,  600));
    tbl.push_back(mk(1, 0, 0, 4'b0101,  600,  600, 1, 0, 4'b0101, 4'b0000,  600));
    tbl.push_back(mk(0, 0, 0, 4'b0100,  600,  601, 0, 0, 4'b0100, 4'b0000,  601));
    tbl.push_back(mk(0, 0, 1, 4'b0100,  600,  602, 0, 0, 4'b0000, 4'b0000,  602));

    // Reset state while rst_n is held low.
    current_time = 11'd123;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ringing", int'(ringing), 0);
    check("reset.snoozed", int'(snoozed), 0);
    check("reset.display", int'(display), 0);
    check("reset.sound",   int'(sound_alarm), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("vec%0d", k));

    // Auto-timeout after RING_LIMIT ticks; the RING_LIMIT = 0 instance keeps ringing.
    apply(mk(1, 0, 0, 4'b0001, 500, 500, 1, 0, 4'b0001, 4'b0000, 500), "tmo.start");
    for (int k = 1; k <= 50; k++) begin
      apply(mk(1, 0, 0, 4'b0001, 500, 500 + k, 0, 0, (k < 10) ? 4'b0001 : 4'b0000, 4'b0000,
               500 + k), $sformatf("tmo.tick%0d", k));
      if (k == 10 || k == 50) begin
        check($sformatf("nolimit.ringing%0d", k), int'(ringing_nl), 1);
        check($sformatf("nolimit.sound%0d", k), int'(sound_nl), 1);
      end
    end
    apply(mk(0, 0, 1, 4'b0001, 500, 560, 0, 0, 4'b0000, 4'b0000, 560), "tmo.stop");
    check("nolimit.stopped", int'(ringing_nl), 0);

    // Asynchronous reset in the middle of a snooze.
    apply(mk(1, 0, 0, 4'b0001, 700, 700, 1, 0, 4'b0001, 4'b0000, 700), "ar.ring");
    apply(mk(0, 1, 0, 4'b0001, 700, 700, 1, 0, 4'b0000, 4'b0001, 700), "ar.snooze");
    apply(mk(0, 0, 0, 4'b0001, 700, 701, 1, 0, 4'b0000, 4'b0001, 705), "ar.shown");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.ringing", int'(ringing), 0);
    check("ar.snoozed", int'(snoozed), 0);
    check("ar.display", int'(display), 0);
    check("ar.sound",   int'(sound_alarm), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 0, 4'b0001, 700, 705, 0, 0, 4'b0000, 4'b0000, 705), "ar.oldtarget");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
